// File: rtl/pong_if.sv
// Game-core bus: tick/start/paddle masks in, ball position, scores, state and pulses out.
interface pong_if #(
  parameter int unsigned COORD_W = 4,
  parameter int unsigned SCORE_W = 4
);
  localparam int unsigned N = 2 ** COORD_W;

  logic               tick;
  logic               start;
  logic [N-1:0]       lpaddle;
  logic [N-1:0]       rpaddle;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic [SCORE_W-1:0] lscore;
  logic [SCORE_W-1:0] rscore;
  logic [2:0]         state;
  logic               winner;
  logic               hit;
  logic               miss;

  modport master (
    output tick, start, lpaddle, rpaddle,
    input  x, y, lscore, rscore, state, winner, hit, miss
  );

  modport slave (
    input  tick, start, lpaddle, rpaddle,
    output x, y, lscore, rscore, state, winner, hit, miss
  );
endinterface

// File: rtl/pong_engine.sv
// Pong game core: ball physics, paddle collision, scoring and match FSM,
// advanced by a one-cycle tick enable.
module pong_engine #(
  parameter int unsigned COORD_W     = 4,
  parameter int unsigned BALL_PERIOD = 20,
  parameter int unsigned MIN_PERIOD  = 6,
  parameter int unsigned SPEEDUP     = 1,
  parameter int unsigned SCORE_W     = 4,
  parameter int unsigned WIN_SCORE   = 9,
  parameter int unsigned PAUSE_TICKS = 50
) (
  input logic  clk,
  input logic  reset,
  pong_if.slave bus
);
  localparam int unsigned N       = 2 ** COORD_W;
  localparam int unsigned CNT_MAX = (BALL_PERIOD > PAUSE_TICKS) ? BALL_PERIOD : PAUSE_TICKS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [COORD_W-1:0] MAX_C = COORD_W'(N - 1);
  localparam logic [COORD_W-1:0] MID_C = COORD_W'(N / 2);
  localparam logic [SCORE_W-1:0] WIN_C = SCORE_W'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
  logic               serve_dy_neg_q, serve_dy_neg_d;
  logic               last_right_q, last_right_d;
  logic [SCORE_W-1:0] lscore_q, lscore_d, rscore_q, rscore_d;
  logic               winner_q, winner_d, hit_q, hit_d, miss_q, miss_d;
  logic [CNT_W-1:0]   period_q, period_d, cnt_q, cnt_d;
  logic               start_q;

  logic               start_edge, move_due, serve_done, pause_done, win, serve_entry;
  logic               dy_neg_m, left_edge, right_edge, lhit, lmiss, rhit, rmiss;
  logic [COORD_W-1:0] y_m;
  logic [CNT_W-1:0]   period_dec;

  assign start_edge  = bus.start && !start_q;
  assign serve_done  = bus.tick && (cnt_q == CNT_W'(BALL_PERIOD - 1));
  assign move_due    = bus.tick && (state_q == S_PLAY) && (cnt_q == period_q - CNT_W'(1));
  assign pause_done  = bus.tick && (cnt_q == CNT_W'(PAUSE_TICKS - 1));
  assign win         = (lscore_q == WIN_C) || (rscore_q == WIN_C);
  assign serve_entry = (state_d == S_SERVE) && (state_q != S_SERVE);

  // Wall reflection first; the paddle test uses the reflected row.
  assign dy_neg_m   = ((y_q == '0) && dy_neg_q)    ? 1'b0 :
                      ((y_q == MAX_C) && !dy_neg_q) ? 1'b1 : dy_neg_q;
  assign y_m        = dy_neg_m ? y_q - COORD_W'(1) : y_q + COORD_W'(1);
  assign left_edge  = (x_q == COORD_W'(1)) && dx_neg_q;
  assign right_edge = (x_q == MAX_C - COORD_W'(1)) && !dx_neg_q;
  assign lhit       = left_edge && bus.lpaddle[y_m];
  assign lmiss      = left_edge && !bus.lpaddle[y_m];
  assign rhit       = right_edge && bus.rpaddle[y_m];
  assign rmiss      = right_edge && !bus.rpaddle[y_m];
  assign period_dec = (32'(period_q) >= MIN_PERIOD + SPEEDUP) ? period_q - CNT_W'(SPEEDUP)
                                                               : CNT_W'(MIN_PERIOD);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_edge) state_d = S_SERVE;
      S_SERVE: if (serve_done) state_d = S_PLAY;
      S_PLAY:  if (move_due && (lmiss || rmiss)) state_d = S_POINT;
      S_POINT: if (pause_done) state_d = win ? S_OVER : S_SERVE;
      S_OVER:  if (start_edge) state_d = S_SERVE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    x_d            = x_q;
    y_d            = y_q;
    dx_neg_d       = dx_neg_q;
    dy_neg_d       = dy_neg_q;
    serve_dy_neg_d = serve_dy_neg_q;
    last_right_d   = last_right_q;
    lscore_d       = lscore_q;
    rscore_d       = rscore_q;
    winner_d       = winner_q;
    period_d       = period_q;
    cnt_d          = cnt_q;
    hit_d          = 1'b0;
    miss_d         = 1'b0;

    case (state_q)
      S_SERVE: if (bus.tick) cnt_d = serve_done ? '0 : cnt_q + CNT_W'(1);
      S_PLAY: begin
        if (move_due) begin
          cnt_d    = '0;
          dy_neg_d = dy_neg_m;
          y_d      = y_m;
          if (lhit) begin
            x_d      = COORD_W'(2);
            dx_neg_d = 1'b0;
            hit_d    = 1'b1;
            period_d = period_dec;
          end else if (lmiss) begin
            x_d          = '0;
            rscore_d     = (rscore_q == WIN_C) ? rscore_q : rscore_q + SCORE_W'(1);
            miss_d       = 1'b1;
            last_right_d = 1'b1;
          end else if (rhit) begin
            x_d      = MAX_C - COORD_W'(2);
            dx_neg_d = 1'b1;
            hit_d    = 1'b1;
            period_d = period_dec;
          end else if (rmiss) begin
            x_d          = MAX_C;
            lscore_d     = (lscore_q == WIN_C) ? lscore_q : lscore_q + SCORE_W'(1);
            miss_d       = 1'b1;
            last_right_d = 1'b0;
          end else begin
            x_d = dx_neg_q ? x_q - COORD_W'(1) : x_q + COORD_W'(1);
          end
        end else if (bus.tick) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_POINT: begin
        if (pause_done) begin
          cnt_d = '0;
          if (win) winner_d = (rscore_q == WIN_C);
        end else if (bus.tick) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase

    // Serve setup; direction depends on where the serve came from.
    if (serve_entry) begin
      x_d      = MID_C;
      y_d      = MID_C;
      period_d = CNT_W'(BALL_PERIOD);
      cnt_d    = '0;
      if (state_q == S_POINT) begin
        dx_neg_d       = last_right_q;
        serve_dy_neg_d = !serve_dy_neg_q;
        dy_neg_d       = !serve_dy_neg_q;
      end else if (state_q == S_OVER) begin
        lscore_d       = '0;
        rscore_d       = '0;
        dx_neg_d       = 1'b1;
        dy_neg_d       = 1'b1;
        serve_dy_neg_d = 1'b1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    start_q <= bus.start;
    if (reset) begin
      x_q            <= MID_C;
      y_q            <= MID_C;
      dx_neg_q       <= 1'b1;
      dy_neg_q       <= 1'b1;
      serve_dy_neg_q <= 1'b1;
      last_right_q   <= 1'b0;
      lscore_q       <= '0;
      rscore_q       <= '0;
      winner_q       <= 1'b0;
      hit_q          <= 1'b0;
      miss_q         <= 1'b0;
      period_q       <= CNT_W'(BALL_PERIOD);
      cnt_q          <= '0;
    end else begin
      x_q            <= x_d;
      y_q            <= y_d;
      dx_neg_q       <= dx_neg_d;
      dy_neg_q       <= dy_neg_d;
      serve_dy_neg_q <= serve_dy_neg_d;
      last_right_q   <= last_right_d;
      lscore_q       <= lscore_d;
      rscore_q       <= rscore_d;
      winner_q       <= winner_d;
      hit_q          <= hit_d;
      miss_q         <= miss_d;
      period_q       <= period_d;
      cnt_q          <= cnt_d;
    end
  end

  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.lscore = lscore_q;
  assign bus.rscore = rscore_q;
  assign bus.state  = state_q;
  assign bus.winner = winner_q;
  assign bus.hit    = hit_q;
  assign bus.miss   = miss_q;
endmodule

// File: tb/tb_pong_engine.sv
// Directed bench for pong_engine: vector table for exact move timing, plus
// sequences for speed-up clamp, game over/restart and mid-play reset.
module tb_pong_engine;
  localparam int unsigned COORD_W = 4;
  localparam int unsigned SCORE_W = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  pong_if #(.COORD_W(COORD_W), .SCORE_W(SCORE_W)) bus ();

  pong_engine #(
    .COORD_W(COORD_W), .BALL_PERIOD(4), .MIN_PERIOD(2), .SPEEDUP(1),
    .SCORE_W(SCORE_W), .WIN_SCORE(2), .PAUSE_TICKS(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic        rst;
    logic        st;
    logic [15:0] lp;
    logic [15:0] rp;
    int          n;
    logic [20:0] exp_obs;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [20:0] pack_obs(input int x, y, st, ls, rs, h, m);
    return {4'(x), 4'(y), 3'(st), 4'(ls), 4'(rs), 1'(h), 1'(m)};
  endfunction

  task automatic add(input int rst, st, input logic [15:0] lp, rp, input int n,
                     input int ex, ey, es, els, ers, eh, em);
    vec_t v;
    v.rst     = (rst != 0);
    v.st      = (st != 0);
    v.lp      = lp;
    v.rp      = rp;
    v.n       = n;
    v.exp_obs = pack_obs(ex, ey, es, els, ers, eh, em);
    tbl.push_back(v);
  endtask

  function automatic logic [20:0] obs();
    return {bus.x, bus.y, bus.state, bus.lscore, bus.rscore, bus.hit, bus.miss};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input string name, input logic [20:0] act, input logic [20:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got x=%0d y=%0d st=%0d ls=%0d rs=%0d hit=%b miss=%b, want x=%0d y=%0d st=%0d ls=%0d rs=%0d hit=%b miss=%b",
               name, act[20:17], act[16:13], act[12:10], act[9:6], act[5:2], act[1], act[0],
               exp[20:17], exp[16:13], exp[12:10], exp[9:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    int i = 0;
    while (int'(bus.state) != s && i < budget) begin
      step(1);
      i++;
    end
    check_val(name, int'(bus.state), s);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.tick    = 1'b1;
    bus.start   = 1'b0;
    bus.lpaddle = '0;
    bus.rpaddle = '0;
    reset       = 1'b1;

    // Serve, diagonal run to a left miss, pause, then the next serve (dy inverted).
    add(1, 0, 16'h0, 16'h0, 2, 8, 8, 0, 0, 0, 0, 0);
    add(0, 1, 16'h0, 16'h0, 1, 8, 8, 1, 0, 0, 0, 0);
    add(0, 1, 16'h0, 16'h0, 3, 8, 8, 1, 0, 0, 0, 0);
    add(0, 1, 16'h0, 16'h0, 1, 8, 8, 2, 0, 0, 0, 0);
    add(0, 1, 16'h0, 16'h0, 4, 7, 7, 2, 0, 0, 0, 0);
    add(0, 1, 16'h0, 16'h0, 3, 7, 7, 2, 0, 0, 0, 0);
    add(0, 1, 16'h0, 16'h0, 1, 6, 6, 2, 0, 0, 0, 0);
    for (int k = 5; k >= 1; k--) add(0, 1, 16'h0, 16'h0, 4, k, k, 2, 0, 0, 0, 0);
    add(0, 1, 16'h0, 16'h0, 4, 0, 0, 3, 0, 1, 0, 1);
    add(0, 1, 16'h0, 16'h0, 1, 0, 0, 3, 0, 1, 0, 0);
    add(0, 1, 16'h0, 16'h0, 1, 0, 0, 3, 0, 1, 0, 0);
    add(0, 1, 16'h0, 16'h0, 1, 8, 8, 1, 0, 1, 0, 0);
    add(0, 1, 16'h0, 16'h0, 4, 8, 8, 2, 0, 1, 0, 0);
    add(0, 1, 16'h0, 16'h0, 4, 7, 9, 2, 0, 1, 0, 0);
    add(0, 1, 16'h0, 16'h0, 4, 6, 10, 2, 0, 1, 0, 0);
    // Reset with start held: no fire until a fresh edge; then a corner hit.
    add(1, 1, 16'h0, 16'h0, 2, 8, 8, 0, 0, 0, 0, 0);
    add(0, 1, 16'h0, 16'h0, 3, 8, 8, 0, 0, 0, 0, 0);
    add(0, 0, 16'h0, 16'h0, 1, 8, 8, 0, 0, 0, 0, 0);
    add(0, 1, 16'hFFFF, 16'h0, 1, 8, 8, 1, 0, 0, 0, 0);
    add(0, 1, 16'hFFFF, 16'h0, 3, 8, 8, 1, 0, 0, 0, 0);
    add(0, 1, 16'hFFFF, 16'h0, 1, 8, 8, 2, 0, 0, 0, 0);
    for (int k = 7; k >= 1; k--) add(0, 1, 16'hFFFF, 16'h0, 4, k, k, 2, 0, 0, 0, 0);
    add(0, 1, 16'hFFFF, 16'h0, 4, 2, 0, 2, 0, 0, 1, 0);
    add(0, 1, 16'hFFFF, 16'h0, 1, 2, 0, 2, 0, 0, 0, 0);
    add(0, 1, 16'hFFFF, 16'h0, 1, 2, 0, 2, 0, 0, 0, 0);
    add(0, 1, 16'hFFFF, 16'h0, 1, 3, 1, 2, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      reset       = tbl[i].rst;
      bus.start   = tbl[i].st;
      bus.lpaddle = tbl[i].lp;
      bus.rpaddle = tbl[i].rp;
      step(tbl[i].n);
      check_vec($sformatf("row%0d", i), obs(), tbl[i].exp_obs);
    end

    // Speed-up clamp: gap between moves must follow 4,3,2,2,...
    begin
      int cyc = 0, last = 0, hits = 0, moves = 0, exp_gap;
      logic [3:0] prev_x;
      reset = 1'b1; bus.start = 1'b0;
      bus.lpaddle = 16'hFFFF; bus.rpaddle = 16'hFFFF;
      step(2);
      reset = 1'b0; bus.start = 1'b1;
      wait_state(2, 20, "spd_play");
      prev_x = bus.x;
      while (moves < 40 && cyc < 400) begin
        step(1);
        cyc++;
        if (bus.x != prev_x) begin
          exp_gap = (4 - hits > 2) ? 4 - hits : 2;
          check_val($sformatf("spd_gap%0d", moves), cyc - last, exp_gap);
          last = cyc;
          if (bus.hit) hits++;
          prev_x = bus.x;
          moves++;
        end
      end
      check_val("spd_moves", moves, 40);
      check_val("spd_hits", int'(hits >= 3), 1);
      check_val("spd_scores", int'({bus.lscore, bus.rscore}), 0);
    end

    // Game over and restart.
    reset = 1'b1; bus.start = 1'b0; bus.lpaddle = '0; bus.rpaddle = '0;
    step(2);
    reset = 1'b0; bus.start = 1'b1;
    step(1);
    check_val("go_serve1", int'(bus.state), 1);
    wait_state(3, 100, "go_point1");
    check_val("go_rscore1", int'(bus.rscore), 1);
    wait_state(1, 20, "go_serve2");
    wait_state(4, 200, "go_over");
    check_vec("go_over_obs", obs(), pack_obs(0, 14, 4, 0, 2, 0, 0));
    check_val("go_winner", int'(bus.winner), 1);
    step(6);
    check_vec("go_held", obs(), pack_obs(0, 14, 4, 0, 2, 0, 0));
    bus.start = 1'b0;
    step(1);
    bus.start = 1'b1;
    step(1);
    check_vec("go_restart", obs(), pack_obs(8, 8, 1, 0, 0, 0, 0));

    // Reach 1:1, then reset in the middle of play.
    wait_state(3, 100, "rst_point1");
    check_val("rst_rscore1", int'(bus.rscore), 1);
    bus.lpaddle = 16'hFFFF;
    wait_state(1, 20, "rst_serve2");
    wait_state(3, 300, "rst_point2");
    check_val("rst_scores11", int'({bus.lscore, bus.rscore}), 8'h11);
    wait_state(2, 50, "rst_play");
    step(3);
    reset = 1'b1;
    step(1);
    check_vec("rst_mid", obs(), pack_obs(8, 8, 0, 0, 0, 0, 0));
    check_val("rst_winner", int'(bus.winner), 0);
    reset = 1'b0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
